// File: rtl/instr_sequencer_if.sv
// rtl/instr_sequencer_if.sv - program-load handshake between host and instruction sequencer
interface instr_sequencer_if #(
  parameter int DATA_WIDTH = 16
);
  logic                  load_valid;
  logic                  load_ready;
  logic [DATA_WIDTH-1:0] load_data;
  logic                  load_last;

  modport master (output load_valid, load_data, load_last, input load_ready);
  modport slave  (input load_valid, load_data, load_last, output load_ready);
endinterface

// File: rtl/instr_sequencer.sv
// rtl/instr_sequencer.sv - loads a program into RAM, then issues it word by word to the core
// Optional multi-pass looping is enabled with INSTR_SEQ_EPOCH_LOOP_EN.
module instr_sequencer #(
  parameter int         DATA_WIDTH = 16,
  parameter int         ADDR_WIDTH = 8,
  parameter logic [3:0] HALT_OP    = 4'hF
) (
  input  logic                  clock,
  input  logic                  reset,
  instr_sequencer_if.slave      load_if,
  input  logic                  start,
  input  logic                  core_stall,
`ifdef INSTR_SEQ_EPOCH_LOOP_EN
  input  logic [7:0]            epochs,
  output logic [7:0]            epoch,
`endif
  output logic [DATA_WIDTH-1:0] instr_out,
  output logic                  instr_valid,
  output logic [ADDR_WIDTH-1:0] pc,
  output logic                  busy,
  output logic                  done
);

  typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;
  localparam logic [ADDR_WIDTH-1:0] PTR_ONE   = 1;
  localparam logic [ADDR_WIDTH:0]   LEN_ONE   = 1;

  state_t                state;
  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];
  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH:0]   prog_len;

  logic                  accept;
  logic                  load_end;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0] fetch_word;
  logic                  fetch_halt;
  logic                  pass_end;

  assign accept     = load_if.load_valid & load_if.load_ready;
  assign wr_addr    = (state == IDLE) ? '0 : wr_ptr;
  assign load_end   = load_if.load_last || (wr_addr == LAST_ADDR);
  assign fetch_word = mem[pc];
  assign fetch_halt = (fetch_word[DATA_WIDTH-1 -: 4] == HALT_OP);
  // A pass ends on HALT or after the last loaded word, whichever comes first.
  assign pass_end   = fetch_halt || ({1'b0, pc} == (prog_len - LEN_ONE));

`ifdef INSTR_SEQ_EPOCH_LOOP_EN
  logic [7:0] epoch_lat;
  logic       more_epochs;
  assign more_epochs = (epoch < (epoch_lat - 8'd1));
`endif

  // Program RAM has no reset so a program survives a reset of the control path.
  always_ff @(posedge clock) begin
    if (!reset && accept) begin
      mem[wr_addr] <= load_if.load_data;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state              <= IDLE;
      pc                 <= '0;
      wr_ptr             <= '0;
      prog_len           <= '0;
      instr_out          <= '0;
      instr_valid        <= 1'b0;
      done               <= 1'b0;
      busy               <= 1'b0;
      load_if.load_ready <= 1'b1;
`ifdef INSTR_SEQ_EPOCH_LOOP_EN
      epoch              <= '0;
      epoch_lat          <= 8'd1;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          // A load accept takes priority: load_ready is high, so the word must not be dropped.
          if (accept) begin
            if (load_end) begin
              prog_len <= {1'b0, wr_addr} + LEN_ONE;
            end else begin
              prog_len <= '0;
              wr_ptr   <= PTR_ONE;
              state    <= LOAD;
              busy     <= 1'b1;
            end
          end else if (start && (prog_len != '0)) begin
            state              <= RUN;
            busy               <= 1'b1;
            load_if.load_ready <= 1'b0;
            pc                 <= '0;
            instr_valid        <= 1'b0;
`ifdef INSTR_SEQ_EPOCH_LOOP_EN
            epoch              <= '0;
            epoch_lat          <= (epochs == 8'd0) ? 8'd1 : epochs;
`endif
          end
        end
        LOAD: begin
          if (accept) begin
            if (load_end) begin
              prog_len <= {1'b0, wr_ptr} + LEN_ONE;
              state    <= IDLE;
              busy     <= 1'b0;
            end else begin
              wr_ptr <= wr_ptr + PTR_ONE;
            end
          end
        end
        RUN: begin
          if (!core_stall) begin
            instr_out   <= fetch_word;
            instr_valid <= !fetch_halt;
            if (pass_end) begin
`ifdef INSTR_SEQ_EPOCH_LOOP_EN
              if (more_epochs) begin
                pc    <= '0;
                epoch <= epoch + 8'd1;
              end else begin
                state <= DONE;
              end
`else
              state <= DONE;
`endif
            end else begin
              pc <= pc + PTR_ONE;
            end
          end
        end
        DONE: begin
          if (!core_stall) begin
            instr_valid        <= 1'b0;
            done               <= 1'b1;
            state              <= IDLE;
            busy               <= 1'b0;
            load_if.load_ready <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_sequencer.sv
// tb/tb_instr_sequencer.sv - directed self-checking bench for instr_sequencer
module tb_instr_sequencer;
  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        core_stall = 1'b0;
  logic [15:0] instr_out;
  logic        instr_valid;
  logic [7:0]  pc;
  logic        busy;
  logic        done;
`ifdef INSTR_SEQ_EPOCH_LOOP_EN
  logic [7:0]  epochs = 8'd0;
  logic [7:0]  epoch;
`endif

  instr_sequencer_if #(.DATA_WIDTH(16)) load_if ();

  instr_sequencer #(.DATA_WIDTH(16), .ADDR_WIDTH(8), .HALT_OP(4'hF)) dut (
    .clock       (clock),
    .reset       (reset),
    .load_if     (load_if),
    .start       (start),
    .core_stall  (core_stall),
`ifdef INSTR_SEQ_EPOCH_LOOP_EN
    .epochs      (epochs),
    .epoch       (epoch),
`endif
    .instr_out   (instr_out),
    .instr_valid (instr_valid),
    .pc          (pc),
    .busy        (busy),
    .done        (done)
  );

  always #5 clock = ~clock;

  int          pass_cnt = 0;
  int          total_cnt = 0;
  logic [15:0] prog [256];
  logic [15:0] issued_q [$];
  logic [7:0]  epoch_q [$];
  int          cyc_q [$];
  int          done_cnt;
  int          halt_valid_cnt;

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  function automatic logic [15:0] q_at(input int i);
    return (i < issued_q.size()) ? issued_q[i] : 16'hxxxx;
  endfunction

  task automatic load_prog(input int n, input bit use_last);
    for (int i = 0; i < n; i++) begin
      int w = 0;
      while (!load_if.load_ready && w < 20) begin
        tick;
        w++;
      end
      if (w == 20) begin
        total_cnt++;
        $display("FAIL load_ready_timeout: word %0d never accepted", i);
      end
      load_if.load_valid = 1'b1;
      load_if.load_data  = prog[i];
      load_if.load_last  = use_last && (i == n - 1);
      tick;
    end
    load_if.load_valid = 1'b0;
    load_if.load_last  = 1'b0;
  endtask

  task automatic pulse_start;
    start = 1'b1;
    tick;
    start = 1'b0;
  endtask

  task automatic collect(input int cycles);
    issued_q.delete();
    epoch_q.delete();
    cyc_q.delete();
    done_cnt = 0;
    halt_valid_cnt = 0;
    for (int c = 0; c < cycles; c++) begin
      tick;
      if (instr_valid) begin
        issued_q.push_back(instr_out);
        cyc_q.push_back(c);
`ifdef INSTR_SEQ_EPOCH_LOOP_EN
        epoch_q.push_back(epoch);
`endif
        if (instr_out[15:12] == 4'hF) halt_valid_cnt++;
      end
      if (done) done_cnt++;
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    tick;
    tick;
    reset = 1'b0;
    total_cnt++; if (load_if.load_ready !== 1'b1) $display("FAIL reset_load_ready: got %0b want 1", load_if.load_ready); else pass_cnt++;
    total_cnt++; if (busy !== 1'b0) $display("FAIL reset_busy: got %0b want 0", busy); else pass_cnt++;
    total_cnt++; if (instr_valid !== 1'b0) $display("FAIL reset_instr_valid: got %0b want 0", instr_valid); else pass_cnt++;
    total_cnt++; if (done !== 1'b0) $display("FAIL reset_done: got %0b want 0", done); else pass_cnt++;
    total_cnt++; if (pc !== 8'd0) $display("FAIL reset_pc: got %0h want 0", pc); else pass_cnt++;
    total_cnt++; if (instr_out !== 16'h0) $display("FAIL reset_instr_out: got %0h want 0", instr_out); else pass_cnt++;
    total_cnt++; if (dut.prog_len !== 9'd0) $display("FAIL reset_prog_len: got %0d want 0", dut.prog_len); else pass_cnt++;
  endtask

  task automatic test_load;
    prog[0] = 16'h1123; prog[1] = 16'h2456; prog[2] = 16'h3789;
    load_prog(3, 1'b1);
    total_cnt++; if (dut.prog_len !== 9'd3) $display("FAIL load_prog_len: got %0d want 3", dut.prog_len); else pass_cnt++;
    total_cnt++; if (load_if.load_ready !== 1'b1) $display("FAIL load_ready_after: got %0b want 1", load_if.load_ready); else pass_cnt++;
    total_cnt++; if (busy !== 1'b0) $display("FAIL load_busy_after: got %0b want 0", busy); else pass_cnt++;
  endtask

  task automatic test_execution;
    logic [15:0] exp [3];
    exp[0] = 16'h1123; exp[1] = 16'h2456; exp[2] = 16'h3789;
    pulse_start;
    collect(8);
    total_cnt++; if (issued_q.size() !== 3) $display("FAIL exec_count: got %0d want 3", issued_q.size()); else pass_cnt++;
    for (int i = 0; i < 3; i++) begin
      total_cnt++; if (q_at(i) !== exp[i]) $display("FAIL exec_word%0d: got %0h want %0h", i, q_at(i), exp[i]); else pass_cnt++;
    end
    total_cnt++;
    if (cyc_q.size() != 3 || cyc_q[2] - cyc_q[0] != 2) $display("FAIL exec_consecutive: issues not on 3 consecutive cycles (%0d issues)", cyc_q.size());
    else pass_cnt++;
    total_cnt++; if (done_cnt !== 1) $display("FAIL exec_done_pulses: got %0d want 1", done_cnt); else pass_cnt++;
    total_cnt++; if (busy !== 1'b0) $display("FAIL exec_busy_after: got %0b want 0", busy); else pass_cnt++;
  endtask

  task automatic test_back_to_back;
    pulse_start;
    load_if.load_valid = 1'b1;
    load_if.load_data  = 16'hAAAA;
    load_if.load_last  = 1'b1;
    start = 1'b1;
    tick;
    total_cnt++; if (instr_out !== 16'h1123) $display("FAIL b2b_word0: got %0h want 1123", instr_out); else pass_cnt++;
    total_cnt++; if (load_if.load_ready !== 1'b0) $display("FAIL b2b_ready_in_run: got %0b want 0", load_if.load_ready); else pass_cnt++;
    tick;
    total_cnt++; if (instr_out !== 16'h2456) $display("FAIL b2b_word1: got %0h want 2456", instr_out); else pass_cnt++;
    load_if.load_valid = 1'b0;
    load_if.load_last  = 1'b0;
    start = 1'b0;
    tick;
    total_cnt++; if (instr_out !== 16'h3789) $display("FAIL b2b_word2: got %0h want 3789", instr_out); else pass_cnt++;
    tick;
    total_cnt++; if (done !== 1'b1) $display("FAIL b2b_done: got %0b want 1", done); else pass_cnt++;
    total_cnt++; if (dut.prog_len !== 9'd3) $display("FAIL b2b_prog_len: got %0d want 3", dut.prog_len); else pass_cnt++;
  endtask

  task automatic test_stall;
    pulse_start;
    tick;
    total_cnt++; if (instr_out !== 16'h1123) $display("FAIL stall_first: got %0h want 1123", instr_out); else pass_cnt++;
    core_stall = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick;
      total_cnt++; if (instr_out !== 16'h1123) $display("FAIL stall_hold_out%0d: got %0h want 1123", i, instr_out); else pass_cnt++;
      total_cnt++; if (pc !== 8'd1) $display("FAIL stall_hold_pc%0d: got %0h want 1", i, pc); else pass_cnt++;
    end
    core_stall = 1'b0;
    collect(6);
    total_cnt++; if (issued_q.size() !== 2) $display("FAIL stall_resume_count: got %0d want 2", issued_q.size()); else pass_cnt++;
    total_cnt++; if (q_at(0) !== 16'h2456) $display("FAIL stall_resume_w1: got %0h want 2456", q_at(0)); else pass_cnt++;
    total_cnt++; if (q_at(1) !== 16'h3789) $display("FAIL stall_resume_w2: got %0h want 3789", q_at(1)); else pass_cnt++;
    total_cnt++; if (done_cnt !== 1) $display("FAIL stall_done: got %0d want 1", done_cnt); else pass_cnt++;
  endtask

  task automatic test_halt;
    prog[0] = 16'h1123; prog[1] = 16'hF000; prog[2] = 16'h3789;
    load_prog(3, 1'b1);
    pulse_start;
    collect(8);
    total_cnt++; if (issued_q.size() !== 1) $display("FAIL halt_count: got %0d want 1", issued_q.size()); else pass_cnt++;
    total_cnt++; if (q_at(0) !== 16'h1123) $display("FAIL halt_word0: got %0h want 1123", q_at(0)); else pass_cnt++;
    total_cnt++; if (halt_valid_cnt !== 0) $display("FAIL halt_opcode_valid: got %0d want 0", halt_valid_cnt); else pass_cnt++;
    total_cnt++; if (done_cnt !== 1) $display("FAIL halt_done: got %0d want 1", done_cnt); else pass_cnt++;
  endtask

  task automatic test_reset_guard;
    prog[0] = 16'h1123; prog[1] = 16'h2456; prog[2] = 16'h3789;
    load_prog(3, 1'b1);
    pulse_start;
    tick;
    total_cnt++; if (pc !== 8'd1) $display("FAIL rguard_pc_before: got %0h want 1", pc); else pass_cnt++;
    reset = 1'b1;
    tick;
    reset = 1'b0;
    total_cnt++; if (instr_valid !== 1'b0) $display("FAIL rguard_instr_valid: got %0b want 0", instr_valid); else pass_cnt++;
    total_cnt++; if (dut.prog_len !== 9'd0) $display("FAIL rguard_prog_len: got %0d want 0", dut.prog_len); else pass_cnt++;
    total_cnt++; if (done !== 1'b0) $display("FAIL rguard_done: got %0b want 0", done); else pass_cnt++;
    total_cnt++; if (load_if.load_ready !== 1'b1) $display("FAIL rguard_idle_ready: got %0b want 1", load_if.load_ready); else pass_cnt++;
    pulse_start;
    collect(6);
    total_cnt++; if (issued_q.size() !== 0) $display("FAIL rguard_start_ignored: got %0d issues want 0", issued_q.size()); else pass_cnt++;
    total_cnt++; if (done_cnt !== 0) $display("FAIL rguard_no_done: got %0d want 0", done_cnt); else pass_cnt++;
    total_cnt++; if (busy !== 1'b0) $display("FAIL rguard_busy: got %0b want 0", busy); else pass_cnt++;
  endtask

  task automatic test_full_load;
    for (int i = 0; i < 256; i++) prog[i] = 16'h1000 | 16'(i);
    load_prog(256, 1'b0);
    total_cnt++; if (dut.prog_len !== 9'd256) $display("FAIL full_prog_len: got %0d want 256", dut.prog_len); else pass_cnt++;
    total_cnt++; if (busy !== 1'b0) $display("FAIL full_busy: got %0b want 0", busy); else pass_cnt++;
    pulse_start;
    collect(270);
    total_cnt++; if (issued_q.size() !== 256) $display("FAIL full_count: got %0d want 256", issued_q.size()); else pass_cnt++;
    total_cnt++; if (q_at(0) !== 16'h1000) $display("FAIL full_first: got %0h want 1000", q_at(0)); else pass_cnt++;
    total_cnt++; if (q_at(255) !== 16'h10FF) $display("FAIL full_last: got %0h want 10ff", q_at(255)); else pass_cnt++;
    total_cnt++; if (done_cnt !== 1) $display("FAIL full_done: got %0d want 1", done_cnt); else pass_cnt++;
  endtask

`ifdef INSTR_SEQ_EPOCH_LOOP_EN
  task automatic test_epoch;
    logic [15:0] exp [4];
    exp[0] = 16'h1123; exp[1] = 16'h2456; exp[2] = 16'h1123; exp[3] = 16'h2456;
    prog[0] = 16'h1123; prog[1] = 16'h2456;
    load_prog(2, 1'b1);
    epochs = 8'd2;
    pulse_start;
    collect(10);
    total_cnt++; if (issued_q.size() !== 4) $display("FAIL epoch_count: got %0d want 4", issued_q.size()); else pass_cnt++;
    for (int i = 0; i < 4; i++) begin
      total_cnt++; if (q_at(i) !== exp[i]) $display("FAIL epoch_word%0d: got %0h want %0h", i, q_at(i), exp[i]); else pass_cnt++;
    end
    total_cnt++;
    if (epoch_q.size() != 4 || epoch_q[0] !== 8'd0 || epoch_q[2] !== 8'd1) $display("FAIL epoch_values: %0d samples, first pass/second pass epoch not 0/1", epoch_q.size());
    else pass_cnt++;
    total_cnt++; if (done_cnt !== 1) $display("FAIL epoch_done: got %0d want 1", done_cnt); else pass_cnt++;
  endtask
`endif

  initial begin
    load_if.load_valid = 1'b0;
    load_if.load_data  = 16'h0;
    load_if.load_last  = 1'b0;
    test_reset;
    test_load;
    test_execution;
    test_back_to_back;
    test_stall;
    test_halt;
    test_reset_guard;
    test_full_load;
`ifdef INSTR_SEQ_EPOCH_LOOP_EN
    test_epoch;
`endif
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: bench did not finish");
    $fatal(1);
  end
endmodule

// File: doc/instr_sequencer.md
INSTR_SEQUENCER -- requirements
Module: instr_sequencer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16, instruction word width: opcode [15:12], then three 4-bit fields.
REQ-002 SHALL have parameter ADDR_WIDTH, default 8, program RAM address width (depth 2**ADDR_WIDTH).
REQ-003 SHALL have parameter HALT_OP, default 4'hF, opcode that terminates a program pass.
REQ-004 SHALL have port clock  input  1  single clock; all state updates on its rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port load_valid  input  1  host presents a program word.
REQ-007 SHALL have port load_ready  output  1  sequencer accepts a program word.
REQ-008 SHALL have port load_data  input  DATA_WIDTH  program word.
REQ-009 SHALL have port load_last  input  1  qualifies the final word of the program.
REQ-010 SHALL have port start  input  1  single-cycle request to execute the loaded program.
REQ-011 SHALL have port core_stall  input  1  downstream datapath cannot take a new instruction.
REQ-012 SHALL have port instr_out  output  DATA_WIDTH  registered instruction to CU, memory selectors and operand fields.
REQ-013 SHALL have port instr_valid  output  1  instr_out holds an instruction to execute.
REQ-014 SHALL have port pc  output  ADDR_WIDTH  address of the next word to fetch.
REQ-015 SHALL have port busy  output  1  high in LOAD and RUN.
REQ-016 SHALL have port done  output  1  one-cycle pulse at end of execution.

Function
REQ-017 SHALL implement states IDLE, LOAD, RUN, DONE.
REQ-018 SHALL assert load_ready only in IDLE and LOAD; a word is accepted on a cycle with load_valid and load_ready both high.
REQ-019 SHALL write the first accepted word in IDLE to address 0, move to LOAD, and clear prog_len; each later accept writes at wr_ptr, then wr_ptr increments.
REQ-020 SHALL end loading on an accept with load_last high, or on an accept at address 2**ADDR_WIDTH-1; it then sets prog_len to wr_ptr+1 and returns to IDLE.
REQ-021 SHALL honour start only in IDLE with prog_len nonzero; otherwise start is ignored, with no state change.
REQ-022 SHALL, on entering RUN, set pc=0; instr_valid SHALL remain low until the first fetch completes one cycle later.
REQ-023 SHALL, in RUN on each cycle with core_stall low, register instr_out<=mem[pc] and instr_valid<=(mem[pc][15:12]!=HALT_OP).
REQ-024 SHALL, in RUN, increment pc on each such cycle unless the fetched word is HALT_OP or pc==prog_len-1; in either case it goes to DONE, so the last non-HALT word is still issued.
REQ-025 SHALL, while core_stall is high, hold instr_out, instr_valid, pc and state unchanged.
REQ-026 SHALL, in DONE with core_stall low, clear instr_valid, pulse done for exactly one cycle and return to IDLE; with core_stall high it SHALL remain in DONE.
REQ-027 SHALL retain prog_len and RAM contents after DONE, so a later start re-runs the same program without reloading.
REQ-028 SHALL ignore load_valid and start during RUN and DONE.

Reset
REQ-029 SHALL, on reset, enter IDLE and clear pc, wr_ptr, prog_len, instr_out, instr_valid, done and busy to 0; load_ready SHALL be 1 on the first cycle after reset; RAM contents are not cleared.
REQ-030 SHALL, on reset mid-LOAD or mid-RUN, abandon the operation with no done pulse; prog_len=0 forces a reload before the next start.

Configuration
REQ-031 SHALL, with INSTR_SEQ_EPOCH_LOOP_EN defined, add input epochs (8 bits) and output epoch (8 bits); epochs is latched at start, with 0 treated as 1.
REQ-032 SHALL, with INSTR_SEQ_EPOCH_LOOP_EN defined, at end of pass set pc=0, increment epoch and stay in RUN when epoch<latched-1; otherwise it goes to DONE. epoch resets to 0 on reset and on start.
REQ-033 SHALL, without INSTR_SEQ_EPOCH_LOOP_EN, omit epochs and epoch and execute exactly one pass per start.

Verification
REQ-034 SHALL cover loading: load 3 words 0x1123, 0x2456, 0x3789 with load_last on the third -> prog_len=3, state IDLE, load_ready high.
REQ-035 SHALL cover execution: start with no stall -> instr_valid high for 3 consecutive cycles carrying 0x1123, 0x2456, 0x3789; done pulses once; busy low afterwards.
REQ-036 SHALL cover HALT: program 0x1123, 0xF000, 0x3789 -> only 0x1123 issued; instr_valid never high with opcode F; done pulses.
REQ-037 SHALL cover stall: core_stall high for 4 cycles after the first issue -> instr_out stays 0x1123 and pc stays 1; the sequence resumes unchanged after release.
REQ-038 SHALL cover reset and start guards: reset in RUN at pc=1 -> next cycle IDLE, instr_valid=0, prog_len=0, no done; start then ignored.
REQ-039 SHALL cover epoch looping: with INSTR_SEQ_EPOCH_LOOP_EN, epochs=2, 2-word program -> 4 issues in order w0, w1, w0, w1; epoch 0 then 1; a single done pulse.
